// File: rtl/rx_frame_sampler.sv
`default_nettype none
// =============================================================================
// Module   : rx_frame_sampler
// Purpose  : Oversampling UART receive framer with configurable data/parity/stop
//            format. Optional RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting.
// Revision : 1.0 - initial parametrised release
// =============================================================================
module rx_frame_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 sampling_clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_enable,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy,
    output logic [7:0]           counter_out
);

    localparam int              c_HALF      = OVERSAMPLE / 2;
    localparam int              c_KW        = $clog2(OVERSAMPLE);
    localparam logic [c_KW-1:0] c_K_LAST    = c_KW'(OVERSAMPLE - 1);
    localparam logic [c_KW-1:0] c_K_MID     = c_KW'(c_HALF);
    localparam logic [c_KW-1:0] c_K_DECIDE  = c_KW'(c_HALF + 1);
    localparam logic [3:0]      c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [c_KW-1:0]        r_k;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr_pend;
    logic                   r_ferr_pend;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_parity_error;
    logic                   r_framing_error;
    logic                   r_busy;

    logic                   w_rxs;
    logic                   w_bit;
    logic                   w_decide;
    logic                   w_par_exp;
    logic [c_KW-1:0]        w_k_next;

    always_ff @(posedge sampling_clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [c_KW-1:0] c_K_EARLY = c_KW'(c_HALF - 1);

    logic r_samp_early;
    logic r_samp_mid;

    always_ff @(posedge sampling_clock) begin
        if (reset) begin
            r_samp_early <= 1'b1;
            r_samp_mid   <= 1'b1;
        end else begin
            if (r_k == c_K_EARLY) r_samp_early <= w_rxs;
            if (r_k == c_K_MID)   r_samp_mid   <= w_rxs;
        end
    end

    // Third vote is the live sample at the decision tick itself.
    assign w_bit = (r_samp_early & r_samp_mid) |
                   (r_samp_early & w_rxs) |
                   (r_samp_mid   & w_rxs);
`else
    logic r_samp_mid;

    always_ff @(posedge sampling_clock) begin
        if (reset) begin
            r_samp_mid <= 1'b1;
        end else if (r_k == c_K_MID) begin
            r_samp_mid <= w_rxs;
        end
    end

    assign w_bit = r_samp_mid;
`endif

    assign w_k_next  = (r_k == c_K_LAST) ? '0 : r_k + 1'b1;
    assign w_decide  = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH) && (r_k == c_K_DECIDE);
    assign w_par_exp = (PARITY_MODE == 1) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge sampling_clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_k             <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_perr_pend     <= 1'b0;
            r_ferr_pend     <= 1'b0;
            r_data_out      <= '0;
            r_data_valid    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (!rx_enable) begin
                r_state <= S_IDLE;
                r_k     <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_k <= '0;
                        if (!w_rxs) begin
                            r_state <= S_START;
                            r_k     <= w_k_next;
                            r_busy  <= 1'b1;
                        end
                    end

                    S_START: begin
                        r_k <= w_k_next;
                        if (w_decide) begin
                            if (w_bit) begin
                                r_state <= S_IDLE;
                                r_k     <= '0;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state     <= S_DATA;
                                r_bit_cnt   <= '0;
                                r_perr_pend <= 1'b0;
                                r_ferr_pend <= 1'b0;
                            end
                        end
                    end

                    S_DATA: begin
                        r_k <= w_k_next;
                        if (w_decide) begin
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == c_LAST_DATA) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_PARITY: begin
                        r_k <= w_k_next;
                        if (w_decide) begin
                            r_perr_pend <= (w_bit != w_par_exp);
                            r_bit_cnt   <= '0;
                            r_state     <= S_STOP;
                        end
                    end

                    S_STOP: begin
                        r_k <= w_k_next;
                        if (w_decide) begin
                            if (r_bit_cnt == c_LAST_STOP) begin
                                r_data_valid    <= 1'b1;
                                r_data_out      <= r_shift;
                                r_parity_error  <= r_perr_pend;
                                r_framing_error <= r_ferr_pend | ~w_bit;
                                r_k             <= '0;
                                // A low final stop means a break; wait for the line to recover.
                                if (w_bit) begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= S_WAIT_HIGH;
                                end
                            end else begin
                                r_ferr_pend <= r_ferr_pend | ~w_bit;
                                r_bit_cnt   <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_WAIT_HIGH: begin
                        r_k <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign busy          = r_busy;
    assign counter_out   = 8'(r_k);

endmodule
`default_nettype wire
